// File: rtl/tmr_vote_controller.sv
// Sequencer around a 3-input bitwise majority voter: collects one word per replica,
// tolerates one straggler after a bounded wait, and tracks replicas that keep disagreeing.
module tmr_vote_controller #(
  parameter int WIDTH        = 8,
  parameter int TIMEOUT      = 15,
  parameter int FAULT_THRESH = 3,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       in_valid,
  output logic [2:0]       in_ready,
  input  logic [WIDTH-1:0] in_data_a,
  input  logic [WIDTH-1:0] in_data_b,
  input  logic [WIDTH-1:0] in_data_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_agree,
  output logic             out_degraded,
  output logic             timeout_err,
  output logic [2:0]       fault,
  input  logic             clear_fault
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(FAULT_THRESH);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VOTE,
    HOLD
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       captured, captured_nxt;
  logic [2:0]       cap, cap_all;
  logic             two_captured;
  logic [TW-1:0]    timer, timer_nxt;
  logic             timeout_nxt;
  logic [WIDTH-1:0] words [3];
  logic [CNT_W-1:0] cnt [3];
  logic [CNT_W-1:0] cnt_nxt [3];
  logic [2:0]       fault_nxt;
  logic             full_vote;
  logic             pair_equal;
  logic [WIDTH-1:0] vote_data;
  logic             vote_agree;
  logic             vote_degraded;

  assign in_ready     = (state == IDLE || state == COLLECT) ? ~captured : 3'b000;
  assign cap          = in_valid & in_ready;
  assign cap_all      = captured | cap;
  assign two_captured = (cap_all == 3'b011) || (cap_all == 3'b101) || (cap_all == 3'b110);

  // Round sequencing; a capture on the timeout edge still counts toward the round.
  always_comb begin
    state_nxt    = state;
    captured_nxt = cap_all;
    timer_nxt    = timer;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (&cap_all) begin
          state_nxt = VOTE;
        end else if (|cap_all) begin
          state_nxt = COLLECT;
          timer_nxt = '0;
        end
      end
      COLLECT: begin
        timer_nxt = timer + TW'(1);
        if (&cap_all) begin
          state_nxt = VOTE;
        end else if (timer == TW'(TIMEOUT)) begin
          if (two_captured) begin
            state_nxt = VOTE;
          end else begin
            state_nxt    = IDLE;
            captured_nxt = 3'b000;
            timeout_nxt  = 1'b1;
          end
        end
      end
      VOTE: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt    = IDLE;
          captured_nxt = 3'b000;
        end
      end
      default: begin
        state_nxt    = IDLE;
        captured_nxt = 3'b000;
      end
    endcase
  end

  // Vote result; in degraded mode the lower-index captured word wins.
  always_comb begin
    full_vote = &captured;
    case (captured)
      3'b011:  pair_equal = (words[0] == words[1]);
      3'b101:  pair_equal = (words[0] == words[2]);
      3'b110:  pair_equal = (words[1] == words[2]);
      default: pair_equal = 1'b0;
    endcase
    if (full_vote) begin
      vote_data     = (words[0] & words[1]) | (words[0] & words[2]) | (words[1] & words[2]);
      vote_agree    = (words[0] == words[1]) && (words[1] == words[2]);
      vote_degraded = 1'b0;
    end else begin
      vote_data     = captured[0] ? words[0] : words[1];
      vote_agree    = pair_equal;
      vote_degraded = 1'b1;
    end
  end

  // Mismatch counters saturate at the threshold; clear_fault overrides any update.
  always_comb begin
    fault_nxt = fault;
    for (int i = 0; i < 3; i++) begin
      cnt_nxt[i] = cnt[i];
      if (state == VOTE) begin
        if (full_vote) begin
          if (words[i] != vote_data) begin
            cnt_nxt[i] = (cnt[i] >= THRESH) ? cnt[i] : cnt[i] + CNT_W'(1);
          end else begin
            cnt_nxt[i] = '0;
          end
        end else if (!captured[i]) begin
          cnt_nxt[i] = (cnt[i] >= THRESH) ? cnt[i] : cnt[i] + CNT_W'(1);
        end else if (pair_equal) begin
          cnt_nxt[i] = '0;
        end
      end
      if (cnt_nxt[i] == THRESH) begin
        fault_nxt[i] = 1'b1;
      end
      if (clear_fault) begin
        cnt_nxt[i] = '0;
      end
    end
    if (clear_fault) begin
      fault_nxt = 3'b000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      captured     <= 3'b000;
      timer        <= '0;
      timeout_err  <= 1'b0;
      fault        <= 3'b000;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_agree    <= 1'b0;
      out_degraded <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        words[i] <= '0;
        cnt[i]   <= '0;
      end
    end else begin
      state       <= state_nxt;
      captured    <= captured_nxt;
      timer       <= timer_nxt;
      timeout_err <= timeout_nxt;
      fault       <= fault_nxt;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      if (cap[0]) words[0] <= in_data_a;
      if (cap[1]) words[1] <= in_data_b;
      if (cap[2]) words[2] <= in_data_c;
      if (state == VOTE) begin
        out_valid    <= 1'b1;
        out_data     <= vote_data;
        out_agree    <= vote_agree;
        out_degraded <= vote_degraded;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tmr_vote_controller.sv
// Randomized scoreboard bench for tmr_vote_controller: a round-level reference model
// predicts each vote or dropped round, and a monitor checks whatever the DUT presents.
module tb_tmr_vote_controller;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 15;
  localparam int THRESH  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       in_valid;
  logic [2:0]       in_ready;
  logic [WIDTH-1:0] in_data_a, in_data_b, in_data_c;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_agree, out_degraded, timeout_err;
  logic [2:0]       fault;
  logic             clear_fault;

  tmr_vote_controller #(
    .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .FAULT_THRESH(THRESH), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data_a(in_data_a), .in_data_b(in_data_b), .in_data_c(in_data_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_agree(out_agree), .out_degraded(out_degraded), .timeout_err(timeout_err),
    .fault(fault), .clear_fault(clear_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               is_timeout;
    logic [WIDTH-1:0] data;
    bit               agree;
    bit               degraded;
    logic [2:0]       fault;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         issued = 0;
  int         done = 0;
  int         mcnt[3];
  logic [2:0] mfault;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic finishBench();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  // Round-level model: which replicas land inside the window decides the outcome.
  task automatic modelRound(input int da, input int db, input int dc,
                            input logic [WIDTH-1:0] wa, input logic [WIDTH-1:0] wb,
                            input logic [WIDTH-1:0] wc);
    int d[3];
    logic [WIDTH-1:0] w[3];
    bit inc[3];
    int t0, n, ones, lo, hi;
    exp_t e;
    d = '{da, db, dc};
    w = '{wa, wb, wc};
    t0 = 1 << 30;
    for (int i = 0; i < 3; i++) if (d[i] >= 0 && d[i] < t0) t0 = d[i];
    n = 0;
    for (int i = 0; i < 3; i++) begin
      inc[i] = (d[i] >= 0) && (d[i] <= t0 + TIMEOUT + 1);
      n += int'(inc[i]);
    end
    e.is_timeout = 0; e.data = '0; e.agree = 0; e.degraded = 0;
    if (n == 3) begin
      for (int b = 0; b < WIDTH; b++) begin
        ones = int'(w[0][b]) + int'(w[1][b]) + int'(w[2][b]);
        e.data[b] = (ones >= 2);
      end
      e.agree = (w[0] == w[1]) && (w[1] == w[2]);
      for (int i = 0; i < 3; i++)
        mcnt[i] = (w[i] != e.data) ? ((mcnt[i] + 1 > THRESH) ? THRESH : mcnt[i] + 1) : 0;
    end else if (n == 2) begin
      lo = inc[0] ? 0 : 1;
      hi = inc[2] ? 2 : 1;
      e.data = w[lo];
      e.agree = (w[lo] == w[hi]);
      e.degraded = 1;
      for (int i = 0; i < 3; i++) begin
        if (!inc[i]) mcnt[i] = (mcnt[i] + 1 > THRESH) ? THRESH : mcnt[i] + 1;
        else if (e.agree) mcnt[i] = 0;
      end
    end else begin
      e.is_timeout = 1;
    end
    for (int i = 0; i < 3; i++) if (mcnt[i] == THRESH) mfault[i] = 1'b1;
    e.fault = mfault;
    sb.push_back(e);
    issued++;
  endtask

  task automatic driveRound(input int da, input int db, input int dc,
                            input logic [WIDTH-1:0] wa, input logic [WIDTH-1:0] wb,
                            input logic [WIDTH-1:0] wc, input int pct);
    int maxd;
    maxd = da;
    if (db > maxd) maxd = db;
    if (dc > maxd) maxd = dc;
    in_data_a = wa; in_data_b = wb; in_data_c = wc;
    for (int c = 0; c <= maxd; c++) begin
      @(negedge clk);
      in_valid  = {dc == c, db == c, da == c};
      out_ready = ($urandom_range(0, 99) < pct);
    end
    @(negedge clk);
    in_valid = 3'b000;
  endtask

  task automatic waitDone(input int pct);
    int k;
    k = 0;
    while (done != issued && k < 400) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 99) < pct);
      k++;
    end
    if (done != issued) begin
      checkOutput("round_completion", 32'(done), 32'(issued));
      finishBench();
    end
  endtask

  task automatic applyStimulus(input int da, input int db, input int dc,
                               input logic [WIDTH-1:0] wa, input logic [WIDTH-1:0] wb,
                               input logic [WIDTH-1:0] wc, input int pct);
    modelRound(da, db, dc, wa, wb, wc);
    driveRound(da, db, dc, wa, wb, wc, pct);
    waitDone(pct);
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear_fault = 1'b1;
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    mfault = 3'b000;
    @(negedge clk);
    clear_fault = 1'b0;
    #1 checkOutput("fault_cleared", 32'(fault), 32'(mfault));
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0 || sb[0].is_timeout) begin
          checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          checkOutput("out_data", 32'(out_data), 32'(sb[0].data));
          checkOutput("out_agree", 32'(out_agree), 32'(sb[0].agree));
          checkOutput("out_degraded", 32'(out_degraded), 32'(sb[0].degraded));
          checkOutput("fault_at_vote", 32'(fault), 32'(sb[0].fault));
          checkOutput("in_ready_hold", 32'(in_ready), 32'd0);
          if (out_ready) begin
            void'(sb.pop_front());
            done++;
          end
        end
      end
      if (timeout_err) begin
        if (sb.size() == 0 || !sb[0].is_timeout) begin
          checkOutput("unexpected_timeout_err", 32'(timeout_err), 32'd0);
        end else begin
          checkOutput("in_ready_after_timeout", 32'(in_ready), 32'h7);
          checkOutput("fault_at_timeout", 32'(fault), 32'(sb[0].fault));
          void'(sb.pop_front());
          done++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    n_err++;
    finishBench();
  end

  initial begin
    int first, t0, r, bad, n;
    int d[3];
    logic [WIDTH-1:0] w[3];
    logic [WIDTH-1:0] base;

    rst = 1'b1; in_valid = 3'b000; out_ready = 1'b0; clear_fault = 1'b0;
    in_data_a = '0; in_data_b = '0; in_data_c = '0;
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    mfault = 3'b000;
    @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'h7);
    checkOutput("reset_fault", 32'(fault), 32'd0);
    checkOutput("reset_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All three at once: result one cycle after VOTE, inputs blocked until handshake.
    out_ready = 1'b1;
    modelRound(0, 0, 0, 8'h5A, 8'h5A, 8'h5A);
    @(negedge clk);
    in_valid = 3'b111; in_data_a = 8'h5A; in_data_b = 8'h5A; in_data_c = 8'h5A;
    @(negedge clk);
    in_valid = 3'b000;
    #1;
    checkOutput("vote_state_out_valid", 32'(out_valid), 32'd0);
    checkOutput("vote_state_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1 checkOutput("latency_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("post_handshake_in_ready", 32'(in_ready), 32'h7);
    checkOutput("post_handshake_out_valid", 32'(out_valid), 32'd0);
    waitDone(100);

    // Replica C repeatedly outvoted.
    repeat (3) applyStimulus(0, 0, 0, 8'hF0, 8'hF0, 8'h0F, 100);
    #1 checkOutput("fault_c_set", 32'(fault), 32'h4);
    applyStimulus(0, 0, 0, 8'hF0, 8'hF0, 8'hF0, 100);
    #1 checkOutput("fault_c_sticky", 32'(fault), 32'h4);
    pulseClear();

    // Degraded vote, and a lone replica timing out.
    applyStimulus(0, 2, -1, 8'h3C, 8'h3D, 8'h00, 100);
    applyStimulus(0, 5, TIMEOUT + 2, 8'h11, 8'h11, 8'h22, 100);
    applyStimulus(0, -1, -1, 8'h77, 8'h00, 8'h00, 100);
    applyStimulus(1, TIMEOUT + 2, -1, 8'h77, 8'h00, 8'h00, 100);
    applyStimulus(3, 3 + TIMEOUT + 1, 3 + TIMEOUT + 1, 8'h81, 8'h18, 8'h81, 100);

    // Randomized rounds; one replica per block is biased to misbehave.
    bad = 0;
    for (int rnd = 0; rnd < 120; rnd++) begin
      if (rnd % 20 == 0) bad = $urandom_range(0, 2);
      base = WIDTH'($urandom);
      for (int i = 0; i < 3; i++) w[i] = base;
      r = $urandom_range(0, 9);
      if (r < 4) w[bad] = base ^ WIDTH'($urandom_range(1, 255));
      else if (r == 4) for (int i = 0; i < 3; i++) w[i] = WIDTH'($urandom);
      first = $urandom_range(0, 2);
      t0 = $urandom_range(0, 3);
      n = 0;
      for (int i = 0; i < 3; i++) begin
        r = $urandom_range(0, 9);
        if (i == first) d[i] = t0;
        else if (r < 6) d[i] = t0 + $urandom_range(0, TIMEOUT + 1);
        else if (r == 6) d[i] = t0 + TIMEOUT + 1;
        else d[i] = -1;
        if (d[i] >= 0) n++;
      end
      if (n == 2 && $urandom_range(0, 1) == 1)
        for (int i = 0; i < 3; i++) if (d[i] < 0) d[i] = t0 + TIMEOUT + 2;
      applyStimulus(d[0], d[1], d[2], w[0], w[1], w[2], 70);
      if ($urandom_range(0, 9) == 0) pulseClear();
    end

    // Replica B faulted, then reset while holding a result with inputs all valid.
    repeat (3) applyStimulus(0, 0, 0, 8'h33, 8'hCC, 8'h33, 100);
    out_ready = 1'b0;
    modelRound(0, 0, 0, 8'hA5, 8'hA5, 8'hA4);
    driveRound(0, 0, 0, 8'hA5, 8'hA5, 8'hA4, 0);
    in_valid = 3'b111;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_data_a = WIDTH'($urandom); in_data_b = WIDTH'($urandom); in_data_c = WIDTH'($urandom);
    end
    #1 checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 3'b000;
    sb.delete();
    done = issued;
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    mfault = 3'b000;
    #1;
    checkOutput("midhold_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midhold_reset_fault", 32'(fault), 32'd0);
    checkOutput("midhold_reset_in_ready", 32'(in_ready), 32'h7);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1, 2, 8'h96, 8'h69, 8'h96, 100);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    finishBench();
  end

endmodule
